// File: rtl/fetch_pkg.sv
// Shared widths and the queue entry type for the instruction fetch front end.
package fetch_pkg;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries: head is visible combinationally, flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               push_i,
    input  fetch_entry_t       data_i,
    input  logic               pop_i,
    output fetch_entry_t       head_o,
    output logic [CNT_W-1:0]   count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Space is reserved at issue time, so a push into a full queue is a logic error upstream.
    always_ff @(posedge clk) begin
        if (rst_ni && do_push) assert (count_q != CNT_W'(DEPTH));
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: in-order imem requests, show-ahead {pc,instr} queue, branch redirect flush.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_discarded counter outputs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUTS = 2,
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_discarded
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] pending_q, pending_d, discard_q, discard_d, count;
    logic [CNT_W:0]   reserved;
    logic             issue, rsp, push, pop, drop;
    fetch_entry_t     head, push_entry;

    // Queued plus outstanding never exceeds DEPTH, so every response has a slot waiting.
    assign reserved   = {1'b0, count} + {1'b0, pending_q};
    assign imem_req   = reset & ~redirect & (reserved < (CNT_W + 1)'(DEPTH))
                      & (pending_q < CNT_W'(MAX_OUTS));
    assign imem_addr  = fetch_pc_q;
    assign issue      = imem_req & imem_gnt;
    assign rsp        = reset & imem_rvalid & (pending_q != '0);
    assign drop       = rsp & (redirect | (discard_q != '0));
    assign push       = rsp & ~drop;
    assign pop        = if_valid & if_ready & ~redirect;
    assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        pending_d  = pending_q + CNT_W'(issue) - CNT_W'(rsp);
        discard_d  = discard_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = pending_q - CNT_W'(rsp);
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + PC_W'(4);
            if (push)  resp_pc_d  = resp_pc_q + PC_W'(4);
            if (drop)  discard_d  = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            pending_q  <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            pending_q  <= pending_d;
            discard_q  <= discard_d;
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    always_ff @(posedge clk) begin
        if (reset && imem_rvalid) assert (pending_q != '0);
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (reset),
        .flush_i (redirect),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign if_valid = (count != '0);
    assign if_pc    = if_valid ? head.pc    : '0;
    assign if_instr = if_valid ? head.instr : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_discarded_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            if (push && perf_fetched_q != '1)   perf_fetched_q   <= perf_fetched_q + 32'd1;
            if (drop && perf_discarded_q != '1) perf_discarded_q <= perf_discarded_q + 32'd1;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: behavioural imem model, expected entries queued at each grant.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset, redirect, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready;
    logic [63:0] redirect_pc, imem_addr, if_pc;
    logic [31:0] imem_rdata, if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_discarded;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .MAX_OUTS(2), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    typedef struct { logic [63:0] addr; int due; } req_t;
    typedef struct { logic req; logic [63:0] addr; logic ifv; logic [63:0] pc; logic [31:0] instr; bit pop; } samp_t;

    req_t         inflight[$];
    fetch_entry_t sb[$];
    logic [63:0]  exp_pc;
    int           cyc, lat, stale_cnt, pushes, drops;
    bit           gnt_en;
    int           checks, errors;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    // One clock: sample DUT at negedge+1, then update the memory model and expectations after posedge.
    task automatic cycle(output samp_t s);
        bit rs, rd, rv, hs;
        logic [63:0] rd_pc;
        @(negedge clk); #1;
        s.req = imem_req; s.addr = imem_addr; s.ifv = if_valid; s.pc = if_pc; s.instr = if_instr;
        rs = reset; rd = redirect; rd_pc = redirect_pc; rv = imem_rvalid;
        hs = imem_req && imem_gnt;
        s.pop = rs && !rd && if_valid && if_ready;
        @(posedge clk); #1;
        cyc++;
        if (!rs) begin
            inflight.delete(); sb.delete(); exp_pc = RST_PC;
            stale_cnt = 0; pushes = 0; drops = 0;
        end else begin
            if (rv && inflight.size() > 0) begin
                void'(inflight.pop_front());
                if (rd || stale_cnt > 0) begin
                    drops++;
                    if (!rd) stale_cnt--;
                end else pushes++;
            end
            if (rd) begin
                sb.delete(); exp_pc = rd_pc; stale_cnt = inflight.size();
            end else if (hs) begin
                inflight.push_back('{addr: s.addr, due: cyc + lat - 1});
                sb.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
                exp_pc += 64'd4;
            end
        end
        imem_rvalid = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rdata  = imem_rvalid ? instr_of(inflight[0].addr) : 32'h0;
        imem_gnt    = gnt_en;
    endtask

    task automatic test_reset();
        samp_t s;
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        gnt_en = 1'b1; lat = 1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (4) cycle(s);
        checks++; if (s.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", s.req); end
        checks++; if (s.ifv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", s.ifv); end
        checks++; if (s.pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h, expected 0", s.pc); end
        checks++; if (s.instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h, expected 0", s.instr); end
        reset = 1'b1;
        cycle(s);
        checks++;
        if (s.req !== 1'b1 || s.addr !== RST_PC) begin
            errors++; $display("FAIL reset_first_req: got req=%b addr=%h, expected req=1 addr=%h", s.req, s.addr, RST_PC);
        end
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_stream();
        samp_t s; fetch_entry_t e;
        int npop = 0, gaps = 0; bit started = 0;
        if_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            cycle(s);
            if (s.pop) begin
                started = 1; npop++; checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL stream_pop: got pc=%h, expected no entry", s.pc); end
                else begin
                    e = sb.pop_front();
                    if (s.pc !== e.pc || s.instr !== e.instr) begin
                        errors++; $display("FAIL stream_pop: got pc=%h instr=%h, expected pc=%h instr=%h", s.pc, s.instr, e.pc, e.instr);
                    end
                end
            end else if (started) gaps++;
        end
        checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d idle cycles, expected 0", gaps); end
        checks++; if (npop < 20) begin errors++; $display("FAIL stream_count: got %0d pops, expected >= 20", npop); end
        $display("test_stream: %0d pops, %0d gaps", npop, gaps);
    endtask

    task automatic test_back_to_back();
        samp_t s; fetch_entry_t e;
        int popped = 0, k = 0;
        reset = 1'b0; if_ready = 1'b0; lat = 1;
        repeat (2) cycle(s);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(s);
            checks++; if (sb.size() > 4) begin errors++; $display("FAIL bp_reserved: got %0d, expected <= 4", sb.size()); end
        end
        checks++; if (s.req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, expected 0", s.req); end
        checks++; if (s.ifv !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, expected 1", s.ifv); end
        checks++; if (sb.size() != 4) begin errors++; $display("FAIL bp_queued: got %0d, expected 4", sb.size()); end
        if_ready = 1'b1;
        while (popped < 4 && k < 20) begin
            cycle(s); k++;
            if (s.pop) begin
                checks++;
                if (s.pc !== 64'(popped * 4)) begin errors++; $display("FAIL bp_order: got pc=%h, expected %h", s.pc, 64'(popped * 4)); end
                e = sb.pop_front();
                if (s.instr !== e.instr) begin errors++; $display("FAIL bp_instr: got %h, expected %h", s.instr, e.instr); end
                popped++;
            end
        end
        checks++; if (popped != 4 || k != 4) begin errors++; $display("FAIL bp_drain: got %0d pops in %0d cycles, expected 4 in 4", popped, k); end
        $display("test_back_to_back: %0d pops in %0d cycles", popped, k);
    endtask

    task automatic test_redirect();
        samp_t s; fetch_entry_t e;
        bit found = 0, got = 0;
        reset = 1'b0; if_ready = 1'b1; lat = 4;
        repeat (2) cycle(s);
        reset = 1'b1;
        for (int k = 0; k < 100 && !found; k++) begin
            cycle(s);
            if (s.pop) begin
                checks++; e = sb.pop_front();
                if (s.pc !== e.pc || s.instr !== e.instr) begin
                    errors++; $display("FAIL redir_pre: got pc=%h instr=%h, expected pc=%h instr=%h", s.pc, s.instr, e.pc, e.instr);
                end
            end
            if (inflight.size() == 2 && inflight[0].addr == 64'h20 && !imem_rvalid) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL redir_setup: got timeout, expected 0x20/0x24 outstanding"); return; end
        redirect = 1'b1; redirect_pc = 64'h100;
        cycle(s);
        redirect = 1'b0;
        cycle(s);
        checks++; if (s.ifv !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b, expected 0", s.ifv); end
        for (int k = 0; k < 40 && !got; k++) begin
            cycle(s);
            if (s.pop) begin
                got = 1; checks++; e = sb.pop_front();
                if (s.pc !== 64'h100 || s.instr !== 32'hC0DE_0100 || s.pc !== e.pc) begin
                    errors++; $display("FAIL redir_first: got pc=%h instr=%h, expected pc=100 instr=c0de0100", s.pc, s.instr);
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL redir_timeout: got no output, expected pc=100"); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_discarded !== 32'd2) begin errors++; $display("FAIL perf_discarded: got %0d, expected 2", perf_discarded); end
        checks++; if (perf_fetched !== 32'(pushes)) begin errors++; $display("FAIL perf_fetched: got %0d, expected %0d", perf_fetched, pushes); end
`endif
        $display("test_redirect: first pc=%h, stale dropped %0d", s.pc, drops);
    endtask

    task automatic test_redirect_pop();
        samp_t s; fetch_entry_t e;
        bit found = 0, got = 0;
        reset = 1'b0; if_ready = 1'b0; lat = 2;
        repeat (2) cycle(s);
        reset = 1'b1;
        repeat (6) cycle(s);
        if_ready = 1'b1;
        for (int k = 0; k < 50 && !found; k++) begin
            cycle(s);
            if (s.pop) begin
                checks++; e = sb.pop_front();
                if (s.pc !== e.pc || s.instr !== e.instr) begin
                    errors++; $display("FAIL rp_pre: got pc=%h instr=%h, expected pc=%h instr=%h", s.pc, s.instr, e.pc, e.instr);
                end
            end
            if (inflight.size() == 2 && imem_rvalid && sb.size() > inflight.size()) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rp_setup: got timeout, expected rvalid+pop with pending=2"); return; end
        redirect = 1'b1; redirect_pc = 64'h200;
        cycle(s);
        redirect = 1'b0;
        checks++; if (s.ifv !== 1'b1) begin errors++; $display("FAIL rp_head: got valid=%b, expected 1", s.ifv); end
        cycle(s);
        checks++; if (s.ifv !== 1'b0) begin errors++; $display("FAIL rp_flush: got valid=%b, expected 0", s.ifv); end
        for (int k = 0; k < 40 && !got; k++) begin
            cycle(s);
            if (s.pop) begin
                got = 1; checks++; e = sb.pop_front();
                if (s.pc !== 64'h200 || s.instr !== 32'hC0DE_0200 || s.pc !== e.pc) begin
                    errors++; $display("FAIL rp_first: got pc=%h instr=%h, expected pc=200 instr=c0de0200", s.pc, s.instr);
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rp_timeout: got no output, expected pc=200"); end
        $display("test_redirect_pop: first pc=%h", s.pc);
    endtask

    task automatic test_reset_mid();
        samp_t s; fetch_entry_t e;
        bit found = 0; int npop = 0;
        if_ready = 1'b0; lat = 3;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle(s);
            if (inflight.size() >= 1 && (sb.size() - inflight.size()) >= 2) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rm_setup: got timeout, expected queue>=2 with pending"); return; end
        reset = 1'b0;
        cycle(s);
        checks++; if (s.req !== 1'b0) begin errors++; $display("FAIL rm_req_low: got %b, expected 0", s.req); end
        reset = 1'b1;
        cycle(s);
        checks++; if (s.ifv !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b, expected 0", s.ifv); end
        checks++;
        if (s.req !== 1'b1 || s.addr !== RST_PC) begin
            errors++; $display("FAIL rm_first_req: got req=%b addr=%h, expected req=1 addr=%h", s.req, s.addr, RST_PC);
        end
        if_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle(s);
            if (s.pop) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rm_pop: got pc=%h, expected no entry", s.pc); end
                else begin
                    e = sb.pop_front();
                    if (s.pc !== e.pc || s.instr !== e.instr || (npop == 0 && s.pc !== RST_PC)) begin
                        errors++; $display("FAIL rm_pop: got pc=%h instr=%h, expected pc=%h instr=%h", s.pc, s.instr, e.pc, e.instr);
                    end
                end
                npop++;
            end
        end
        checks++; if (npop == 0) begin errors++; $display("FAIL rm_restart: got 0 pops, expected > 0"); end
        $display("test_reset_mid: %0d pops after reset", npop);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; stale_cnt = 0; pushes = 0; drops = 0; exp_pc = RST_PC;
        test_reset();
        test_stream();
        test_back_to_back();
        test_redirect();
        test_redirect_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish within 20000 cycles");
        $fatal(1, "watchdog");
    end
endmodule
